// File: rtl/cpu_exec_monitor.sv
// cpu_exec_monitor: retire-point cycle/instruction-mix counters, halt detection and PC/instr trace FIFO.
// The trace FIFO and trace ports exist only when MONITOR_TRACE_EN is defined; otherwise they read 0.
module cpu_exec_monitor #(
    parameter int XLEN = 64,
    parameter int CNT_W = 32,
    parameter int TRACE_DEPTH = 16,
    localparam int AW = $clog2(TRACE_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             retire_valid_i,
    input  logic [XLEN-1:0]  retire_pc_i,
    input  logic [31:0]      retire_instr_i,
    input  logic [2:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_value_o,
    output logic             halted_o,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [XLEN-1:0]  trace_pc_o,
    output logic [31:0]      trace_instr_o,
    output logic [LW-1:0]    trace_level_o,
    output logic             trace_overflow_o
);
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic             halted_q, halted_d;
    logic             live, push;
    logic [6:0]       op;
    logic [2:0]       cls;

    always_comb begin
        live = retire_valid_i && !halted_q;
        push = live && retire_instr_i != 32'd0;
        op = retire_instr_i[6:0];
        cls = op == 7'b0110011 ? 3'd2 :
              op == 7'b0000011 ? 3'd3 :
              op == 7'b0100011 ? 3'd4 :
              op == 7'b1100011 ? 3'd5 :
              op == 7'b0010011 ? 3'd6 : 3'd7;
        halted_d = !clear_i && (halted_q || (live && retire_instr_i == 32'd0));
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear_i)
                cnt_d[i] = '0;
            else if (cnt_q[i] != '1 && (i == 0 ? !halted_q : i == 1 ? push : push && cls == 3'(i)))
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            halted_q <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            halted_q <= halted_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt_value_o = cnt_q[cnt_sel_i];
    assign halted_o = halted_q;

`ifdef MONITOR_TRACE_EN
    logic [XLEN-1:0] pc_mem [TRACE_DEPTH];
    logic [31:0]     instr_mem [TRACE_DEPTH];
    logic [LW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic            ovf_q, ovf_d;
    logic            pop, full, wr_en;

    // Pointers carry an extra wrap bit so full and empty differ without a separate flag.
    always_comb begin
        trace_level_o = wr_q - rd_q;
        trace_valid_o = trace_level_o != '0;
        full = trace_level_o == LW'(TRACE_DEPTH);
        pop = trace_valid_o && trace_ready_i;
        wr_en = push && (!full || pop);
        wr_d = clear_i ? '0 : wr_q + LW'(wr_en);
        rd_d = clear_i ? '0 : rd_q + LW'(pop);
        ovf_d = !clear_i && (ovf_q || (push && full && !pop));
        trace_pc_o = trace_valid_o ? pc_mem[rd_q[AW-1:0]] : '0;
        trace_instr_o = trace_valid_o ? instr_mem[rd_q[AW-1:0]] : '0;
        trace_overflow_o = ovf_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            pc_mem[wr_q[AW-1:0]] <= retire_pc_i;
            instr_mem[wr_q[AW-1:0]] <= retire_instr_i;
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{trace_ready_i, retire_pc_i};
    assign trace_valid_o = 1'b0;
    assign trace_pc_o = '0;
    assign trace_instr_o = '0;
    assign trace_level_o = '0;
    assign trace_overflow_o = 1'b0;
`endif
endmodule

// File: doc/cpu_exec_monitor.md
# cpu_exec_monitor

Synthesizable execution monitor that attaches to the retire point of the CPU cores (sequential and later pipelined). It counts cycles, retired instructions and per-class instruction mix, and detects the all-zero halt instruction. It also buffers a PC/instruction trace in a parametrised FIFO that a debug host drains through a valid/ready port. Cycle counting, halt detection and instruction logging become hardware that survives synthesis, not just simulation.

## Interface
- XLEN, 64, width of PC field
- CNT_W, 32, width of every counter; counters saturate at all-ones
- TRACE_DEPTH, 16, trace FIFO entries; power of two, ≥ 2
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous clear of counters, halted, overflow and FIFO; has priority over retire in the same cycle
- retire_valid  in  1  one instruction retires this cycle
- retire_pc  in  XLEN  PC of the retiring instruction
- retire_instr  in  32  encoding of the retiring instruction
- cnt_sel  in  3  counter select: 0 cycles, 1 retired, 2 R-type ALU, 3 load, 4 store, 5 branch, 6 I-type ALU, 7 other
- cnt_value  out  CNT_W  selected counter; combinational mux of registers
- halted  out  1  sticky; the halt instruction has retired
- trace_valid  out  1  FIFO head is valid
- trace_ready  in  1  host accepts the head entry
- trace_pc  out  XLEN  head PC (show-ahead)
- trace_instr  out  32  head instruction (show-ahead)
- trace_level  out  $clog2(TRACE_DEPTH)+1  current occupancy
- trace_overflow  out  1  sticky; at least one trace entry was dropped

## Operation
- Reset values: all counters 0, halted 0, trace_overflow 0, FIFO empty, trace_valid 0, trace_pc 0, trace_instr 0, trace_level 0.
- Cycle counter: increments on every posedge while halted=0 and clear=0, including the edge on which the halt instruction retires.
- Retire with halted=0 and retire_instr≠0:
  - retired +1.
  - Exactly one class counter +1, selected by opcode [6:0]: 0110011 R-type ALU, 0000011 load, 0100011 store, 1100011 branch, 0010011 I-type ALU, anything else other.
  - Push {retire_pc, retire_instr} into the FIFO.
- Retire with halted=0 and retire_instr==0: sets halted. The halt instruction is not counted as retired and is not traced.
- When halted=1: retire_valid is ignored and all counters freeze. FIFO draining continues. Only clear or reset leaves the halted state.
- Saturation: a counter at 2^CNT_W−1 holds its value and does not wrap.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index.
  - Pop when trace_valid && trace_ready.
  - Push when full and no pop in the same cycle: the entry is dropped and trace_overflow is set.
  - Push and pop in the same cycle when full: both take effect, level unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointer wrap-around is transparent to trace_level.
- Reset asserted mid-operation clears everything immediately. Partially drained trace data is lost.

## Timing
- Counter, halted and trace_level updates are visible the cycle after the triggering edge.
- Push-to-trace_valid latency: 1 cycle.
- Pop: the head advances on the same edge as the handshake. The next entry (if any) is presented the following cycle with no bubble.
- cnt_value follows cnt_sel combinationally, with zero cycles of latency.
- clear takes effect on the next posedge. reset takes effect asynchronously.

## Configuration
- MONITOR_TRACE_EN defined: FIFO, trace ports and trace_overflow are implemented as described above.
- MONITOR_TRACE_EN undefined:
  - No FIFO storage is instantiated.
  - trace_valid, trace_pc, trace_instr, trace_level and trace_overflow are tied to 0; trace_ready is ignored.
  - Counters and halt detection are unchanged.

## Test plan
- Instruction mix: reset, then retire beq, addi, addi, addi at PCs 0, 4, 8, 12, then 0x00000000 → retired=4, branch=1, I-type=3, other counters 0, halted=1 one cycle after the halt instruction retires.
- Freeze after halt: after the halt instruction, run 10 more cycles with retire_valid=1 → cycle count unchanged and retired stays 4.
- Overflow, with TRACE_DEPTH=4 and trace_ready=0: retire 6 non-zero instructions at PCs 0 to 20 → trace_level=4, trace_overflow=1. Draining then yields PCs 0, 4, 8, 12 in order, followed by trace_valid=0.
- Full push plus pop: hold the FIFO full and, in one cycle, retire an instruction with trace_ready=1 → trace_level stays 4, trace_overflow stays 0, and the new PC appears last on drain.
- Saturation, with CNT_W=4: 20 cycles without a halt → cycle count reads 15.
- Reset and clear:
  - Assert reset mid-run → all outputs 0 immediately.
  - Pulse clear while retire_valid=1 → counters 0 next cycle and nothing pushed.
  - Build with MONITOR_TRACE_EN undefined → trace_valid stays 0 throughout.
